// File: rtl/rv_stim_gen_pkg.sv
// Shared constants and types for the RV32I stimulus generator.
// Holds the opcode/NOP/LFSR constants, the class and FSM enums and the LFSR step.
package rv_stim_pkg;

  localparam logic [6:0]  OPC_IMM   = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [6:0]  OPC_REG   = 7'b0110011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_REG   = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Galois form: shift left, fold the ejected MSB back through the taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/rv_stim_gen_if.sv
// Valid/ready instruction stream between the generator and its consumer.
interface rv_stim_gen_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input  instr_ready);
  modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/rv_stim_gen_encode.sv
// Combinational field extraction, class selection and legalisation of one
// LFSR state into an RV32I word.
module rv_stim_encode
  import rv_stim_pkg::*;
(
  input  logic [31:0] i_state,
  input  logic [3:0]  i_en_mask,
  input  logic [2:0]  i_load_f3_mask,
  output logic [31:0] o_instr
);

  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [11:0] w_imm;
  logic [1:0]  w_cls_raw;
  logic [3:0]  w_rot;
  logic [1:0]  w_ofs;
  cls_e        w_cls;
  logic [11:0] w_imm_i;
  logic [2:0]  w_f3_ld_leg;
  logic [2:0]  w_f3_ld;
  logic [2:0]  w_f3_st;
  logic [6:0]  w_f7;

  assign w_rd      = i_state[4:0];
  assign w_rs1     = i_state[9:5];
  assign w_rs2     = i_state[14:10];
  assign w_f3      = i_state[17:15];
  assign w_imm     = i_state[29:18];
  assign w_cls_raw = i_state[31:30];

  // Rotate the enable mask so bit0 is the raw class; the first set bit is
  // the distance to the next enabled class in wrap order.
  assign w_rot = 4'({i_en_mask, i_en_mask} >> w_cls_raw);

  always_comb begin
    w_ofs = 2'd3;
    if (w_rot[2]) w_ofs = 2'd2;
    if (w_rot[1]) w_ofs = 2'd1;
    if (w_rot[0]) w_ofs = 2'd0;
  end

  assign w_cls = cls_e'(w_cls_raw + w_ofs);

  always_comb begin
    case (w_f3)
      3'd1:    w_imm_i = w_imm & 12'h01F;
      3'd5:    w_imm_i = w_imm & 12'h41F;
      default: w_imm_i = w_imm;
    endcase
  end

  // Loads 3/6/7 are not RV32I; fold them onto LH/LBU/LHU.
  always_comb begin
    w_f3_ld_leg = w_f3;
    if (w_f3 == 3'd3 || w_f3[2:1] == 2'b11) w_f3_ld_leg = w_f3 & 3'b101;
  end
  assign w_f3_ld = w_f3_ld_leg & i_load_f3_mask;

  // Stores only have SB/SH/SW; 3 maps to SW.
  assign w_f3_st = {1'b0, w_f3[1], w_f3[0] & ~w_f3[1]};

  assign w_f7 = ((w_f3 == 3'd0 || w_f3 == 3'd5) && w_imm[10]) ? 7'h20 : 7'h00;

  always_comb begin
    o_instr = NOP_INSTR;
    if (i_en_mask != 4'd0) begin
      case (w_cls)
        CLS_ALU:   o_instr = {w_imm_i, w_rs1, w_f3, w_rd, OPC_IMM};
        CLS_LOAD:  o_instr = {w_imm, w_rs1, w_f3_ld, w_rd, OPC_LOAD};
        CLS_STORE: o_instr = {w_imm[11:5], w_rs2, w_rs1, w_f3_st, w_imm[4:0], OPC_STORE};
        CLS_REG:   o_instr = {w_f7, w_rs2, w_rs1, w_f3, w_rd, OPC_REG};
        default:   o_instr = NOP_INSTR;
      endcase
    end
  end

endmodule

// File: rtl/rv_stim_gen.sv
// LFSR-driven RV32I instruction stream: warm-up NOPs, MAX_INSTR counted
// instructions, then DONE until restarted.
module rv_stim_gen
  import rv_stim_pkg::*;
#(
  parameter logic [31:0] SEED         = 32'd87,
  parameter int          MAX_INSTR    = 100,
  parameter int          WARMUP       = 2,
  parameter logic [2:0]  LOAD_F3_MASK = 3'b111
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    en_mask,
  input  logic          start,
  rv_stim_gen_if.master bus,
  output logic [15:0]   instr_count,
  output logic          done
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] MAX_CNT  = 16'(MAX_INSTR);
  localparam logic [7:0]  WARM_CNT = 8'(WARMUP);
  localparam state_e      ST_INIT  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_e      r_state;
  logic [31:0] r_lfsr;
  logic [7:0]  r_wcnt;
  logic [15:0] r_count;
  logic        r_valid;
  logic [31:0] r_instr;
  logic        r_done;

  logic [31:0] w_lfsr_nxt;
  logic [31:0] w_enc_cur;
  logic [31:0] w_enc_nxt;
  logic        w_accept;
  logic        w_last;

  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  assign w_accept   = r_valid && bus.instr_ready;
  assign w_last     = (r_count + 16'd1) == MAX_CNT;

  // cur: word for a beat registered without advancing (priming, leaving warm-up);
  // nxt: word following an accepted RUN beat.
  rv_stim_encode u_enc_cur (
    .i_state        (r_lfsr),
    .i_en_mask      (en_mask),
    .i_load_f3_mask (LOAD_F3_MASK),
    .o_instr        (w_enc_cur)
  );

  rv_stim_encode u_enc_nxt (
    .i_state        (w_lfsr_nxt),
    .i_en_mask      (en_mask),
    .i_load_f3_mask (LOAD_F3_MASK),
    .o_instr        (w_enc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_lfsr  <= SEED_EFF;
      r_wcnt  <= WARM_CNT;
      r_count <= 16'd0;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_instr <= NOP_INSTR;
          end else if (w_accept) begin
            if (r_wcnt == 8'd1) begin
              r_state <= ST_RUN;
              r_instr <= w_enc_cur;
            end else begin
              r_wcnt <= r_wcnt - 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_instr <= w_enc_cur;
          end else if (w_accept) begin
            r_lfsr  <= w_lfsr_nxt;
            r_count <= r_count + 16'd1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_instr <= NOP_INSTR;
              r_done  <= 1'b1;
            end else begin
              r_instr <= w_enc_nxt;
            end
          end
        end
        ST_DONE: begin
          // LFSR is kept so a restart continues the sequence.
          if (start) begin
            r_state <= ST_INIT;
            r_wcnt  <= WARM_CNT;
            r_count <= 16'd0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
        end
      endcase
    end
  end

  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign instr_count     = r_count;
  assign done            = r_done;

endmodule

// File: tb/tb_rv_stim_gen.sv
// Bench for rv_stim_gen: directed reset/warm-up/stall/done steps plus randomised
// ready and enable masks checked against a transaction-level reference model.
module tb_rv_stim_gen;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: SEED=1, two warm-up beats, long run
  logic        rstA, startA, readyA, doneA;
  logic [3:0]  enA;
  logic [15:0] cntA;
  rv_stim_gen_if ifA ();
  assign ifA.instr_ready = readyA;

  rv_stim_gen #(.SEED(32'd1), .MAX_INSTR(60000), .WARMUP(2), .LOAD_F3_MASK(3'b111)) dutA (
    .clk(clk), .reset(rstA), .en_mask(enA), .start(startA),
    .bus(ifA), .instr_count(cntA), .done(doneA)
  );

  // DUT B: default seed, no warm-up, three instructions per run, narrowed load funct3
  logic        rstB, startB, readyB, doneB;
  logic [3:0]  enB;
  logic [15:0] cntB;
  rv_stim_gen_if ifB ();
  assign ifB.instr_ready = readyB;

  rv_stim_gen #(.MAX_INSTR(3), .WARMUP(0), .LOAD_F3_MASK(3'b011)) dutB (
    .clk(clk), .reset(rstB), .en_mask(enB), .start(startB),
    .bus(ifB), .instr_count(cntB), .done(doneB)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state for A: beat index since reset, LFSR, counted accepts, mask at registration
  int          m_beat;
  logic [31:0] m_lfsr;
  logic [15:0] m_cntA;
  logic [3:0]  m_regmask;
  logic [31:0] lfsB;
  logic [31:0] exp031 [4];

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] t;
    t = s << 1;
    if (s[31]) t = t ^ 32'h0040_0007;
    return t;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] s, input logic [3:0] m,
                                           input logic [2:0] lm);
    logic [31:0] rd, rs1, rs2, f3, imm, im, f7;
    logic [2:0]  f3s;
    logic [1:0]  c;
    logic [31:0] ld_tab [8];
    logic [31:0] st_tab [8];
    ld_tab = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd4, 32'd5, 32'd4, 32'd5};
    st_tab = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd0, 32'd1, 32'd2, 32'd2};
    rd  = s % 32;
    rs1 = (s / 32) % 32;
    rs2 = (s / 1024) % 32;
    f3  = (s / 32768) % 8;
    imm = (s / 262144) % 4096;
    f3s = s[17:15];
    c   = s[31:30];
    if (m == 4'd0) return NOP;
    for (int k = 0; k < 4; k++) if (!m[c]) c = c + 2'd1;
    case (c)
      2'd0: begin
        im = imm;
        if (f3 == 32'd1) im = imm % 32;
        else if (f3 == 32'd5) im = (imm % 32) + (imm & 32'd1024);
        return (im << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      end
      2'd1: return (imm << 20) | (rs1 << 15) | ((ld_tab[f3s] & {29'd0, lm}) << 12) | (rd << 7) | 32'h03;
      2'd2: return ((imm / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (st_tab[f3s] << 12)
                   | ((imm % 32) << 7) | 32'h23;
      default: begin
        f7 = ((f3 == 32'd0 || f3 == 32'd5) && ((imm / 1024) % 2 == 32'd1)) ? 32'd32 : 32'd0;
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
    endcase
  endfunction

  function automatic logic [31:0] expA();
    return (m_beat < 2) ? NOP : ref_word(m_lfsr, m_regmask, 3'b111);
  endfunction

  // One RUN/warm-up cycle of A: compare against the model, then advance it on accept.
  task automatic stepA(input string tag);
    chk(32'(ifA.instr_valid), 32'd1, {tag, "_valid"});
    chk(ifA.instr, expA(), {tag, "_instr"});
    chk(32'(cntA), 32'(m_cntA), {tag, "_count"});
    chk(32'(doneA), 32'd0, {tag, "_done"});
    if (readyA) begin
      if (m_beat >= 2) begin
        m_lfsr = ref_next(m_lfsr);
        m_cntA = m_cntA + 16'd1;
      end
      m_beat++;
      m_regmask = enA;
    end
    tick();
  endtask

  task automatic resetA();
    rstA = 1'b0;
    tick();
    chk(32'(ifA.instr_valid), 32'd0, "A_rst_valid");
    chk(ifA.instr, NOP, "A_rst_instr");
    chk(32'(cntA), 32'd0, "A_rst_count");
    chk(32'(doneA), 32'd0, "A_rst_done");
    rstA      = 1'b1;
    m_beat    = 0;
    m_lfsr    = 32'd1;
    m_cntA    = 16'd0;
    m_regmask = enA;
    tick();
  endtask

  task automatic replay031();
    for (int i = 0; i < 4; i++) begin
      readyA = 1'b1;
      chk(ifA.instr, exp031[i], "A_seq031");
      stepA("A_seq");
    end
  endtask

  initial begin
    exp031 = '{NOP, NOP, 32'h0000_0093, 32'h0000_0113};
    rstA = 1'b0; startA = 1'b0; readyA = 1'b0; enA = 4'b0001;
    rstB = 1'b0; startB = 1'b0; readyB = 1'b1; enB = 4'hF;
    tick();
    tick();

    // Reset state, warm-up NOPs and the first two SEED=1 words
    resetA();
    replay031();

    // Stall: word, valid, LFSR and count frozen
    readyA = 1'b0;
    for (int i = 0; i < 5; i++) stepA("A_stall");
    readyA = 1'b1;
    for (int i = 0; i < 3; i++) stepA("A_resume");

    // All classes disabled: counted NOPs
    enA = 4'b0000;
    stepA("A_nop");
    for (int i = 0; i < 5; i++) begin
      chk(ifA.instr, NOP, "A_nop_lit");
      stepA("A_nop");
    end

    // Reset while a beat is pending, then replay from SEED
    enA    = 4'b0001;
    readyA = 1'b0;
    stepA("A_pend");
    resetA();
    replay031();

    // Randomised ready and masks across every en_mask value
    for (int mk = 0; mk < 16; mk++) begin
      for (int c = 0; c < 300; c++) begin
        readyA = ($urandom_range(0, 3) != 0);
        enA    = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'(mk);
        stepA("A_rand");
      end
    end

    // B: no warm-up, DONE after three accepts, restart continues the LFSR
    chk(32'(ifB.instr_valid), 32'd0, "B_rst_valid");
    chk(ifB.instr, NOP, "B_rst_instr");
    chk(32'(cntB), 32'd0, "B_rst_count");
    rstB = 1'b1;
    lfsB = 32'd87;
    tick();
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (r == 0 && k == 1) begin
          readyB = 1'b0;
          startB = 1'b1;
          tick();
          startB = 1'b0;
          readyB = 1'b1;
        end
        chk(32'(ifB.instr_valid), 32'd1, "B_valid");
        chk(ifB.instr, ref_word(lfsB, enB, 3'b011), "B_instr");
        chk(32'(cntB), 32'(k), "B_count");
        chk(32'(doneB), 32'd0, "B_done0");
        tick();
        lfsB = ref_next(lfsB);
      end
      chk(32'(ifB.instr_valid), 32'd0, "B_done_valid");
      chk(32'(doneB), 32'd1, "B_done");
      chk(ifB.instr, NOP, "B_done_instr");
      chk(32'(cntB), 32'd3, "B_done_count");
      tick();
      chk(32'(doneB), 32'd1, "B_done_hold");
      enB    = (r < 3) ? 4'hF : ((r % 2 == 1) ? 4'b0010 : 4'($urandom_range(1, 15)));
      startB = 1'b1;
      tick();
      startB = 1'b0;
      chk(32'(ifB.instr_valid), 32'd0, "B_restart_valid");
      chk(32'(doneB), 32'd0, "B_restart_done");
      chk(32'(cntB), 32'd0, "B_restart_count");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
